// File: rtl/sdram_cmd_responder.sv
// Device-side SDRAM responder: decodes the command bus, tracks mode and open
// banks, runs read/write bursts against an internal store, and flags protocol misuse.
module sdram_cmd_responder #(
    parameter int DATA_W   = 16,
    parameter int STORE_AW = 8,
    parameter int TRCD     = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sdram_cke,
    input  logic              sdram_cs_n,
    input  logic              sdram_ras_n,
    input  logic              sdram_cas_n,
    input  logic              sdram_we_n,
    input  logic [1:0]        sdram_bs,
    input  logic [12:0]       sdram_addr,
    input  logic [DATA_W-1:0] sdram_dq_in,
    output logic [DATA_W-1:0] sdram_dq_out,
    output logic              sdram_dq_oe,
    output logic              mode_valid,
    output logic [2:0]        mode_cas_lat,
    output logic [2:0]        mode_burst_len,
    output logic [3:0]        bank_open,
    output logic              err_flag,
    output logic [2:0]        err_code
);

    localparam int         CW     = STORE_AW - 2;
    localparam logic [3:0] TRCD_C = 4'(TRCD);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    function automatic logic [9:0] burst_len(input logic [2:0] code);
        case (code)
            3'b000:  burst_len = 10'd1;
            3'b001:  burst_len = 10'd2;
            3'b010:  burst_len = 10'd4;
            3'b011:  burst_len = 10'd8;
            3'b111:  burst_len = 10'd512;
            default: burst_len = 10'd1;
        endcase
    endfunction

    // Sequential column step that wraps inside the aligned block selected by mask.
    function automatic logic [8:0] col_next(input logic [8:0] col, input logic [8:0] mask);
        col_next = (col & ~mask) | ((col + 9'd1) & mask);
    endfunction

    state_t              state_q, state_d;
    logic [1:0]          bank_q, bank_d;
    logic [8:0]          col_q, col_d;
    logic [9:0]          rem_q, rem_d;
    logic [8:0]          mask_q, mask_d;
    logic [3:0]          open_q, open_d;
    logic [3:0]          act_cnt_q [4];
    logic [12:0]         row_q [4];
    logic                mode_valid_q;
    logic [2:0]          cl_q, bl_q;
    logic                err_flag_q;
    logic [2:0]          err_code_q;
    logic [2:0]          pv_q;
    logic [DATA_W-1:0]   pd_q [3];
    logic [DATA_W-1:0]   dq_out_q;
    logic                dq_oe_q;
    logic [DATA_W-1:0]   store_q [2**STORE_AW];

    logic                cmd_en_s;
    logic [2:0]          cmd_s;
    logic                is_act_s, is_rd_s, is_wr_s, is_bst_s, is_pre_s, is_ref_s, is_lmr_s;
    logic                rw_ok_s, burst_stop_s;
    logic [9:0]          new_len_s;
    logic [8:0]          new_mask_s;
    logic                issue_s, wr_en_s;
    logic [STORE_AW-1:0] acc_idx_s;
    logic [DATA_W-1:0]   rd_data_s;
    logic                err_hit_s;
    logic [2:0]          err_val_s;
    logic                src_v_s;
    logic [DATA_W-1:0]   src_d_s;

    assign cmd_en_s     = sdram_cke & ~sdram_cs_n;
    assign cmd_s        = {sdram_ras_n, sdram_cas_n, sdram_we_n};
    assign is_act_s     = cmd_en_s && (cmd_s == 3'b011);
    assign is_rd_s      = cmd_en_s && (cmd_s == 3'b101);
    assign is_wr_s      = cmd_en_s && (cmd_s == 3'b100);
    assign is_bst_s     = cmd_en_s && (cmd_s == 3'b110);
    assign is_pre_s     = cmd_en_s && (cmd_s == 3'b010);
    assign is_ref_s     = cmd_en_s && (cmd_s == 3'b001);
    assign is_lmr_s     = cmd_en_s && (cmd_s == 3'b000);
    assign rw_ok_s      = (is_rd_s | is_wr_s) & mode_valid_q & open_q[sdram_bs];
    assign burst_stop_s = is_bst_s | (is_pre_s & (sdram_addr[10] | (sdram_bs == bank_q)));
    assign new_len_s    = burst_len(bl_q);
    assign new_mask_s   = new_len_s[8:0] - 9'd1;
    assign rd_data_s    = store_q[acc_idx_s];
    assign src_v_s      = (cl_q == 3'd2) ? pv_q[1] : pv_q[2];
    assign src_d_s      = (cl_q == 3'd2) ? pd_q[1] : pd_q[2];

    // Burst FSM next state: an accepted READ/WRITE always wins over the running burst.
    always_comb begin
        state_d   = state_q;
        bank_d    = bank_q;
        col_d     = col_q;
        rem_d     = rem_q;
        mask_d    = mask_q;
        issue_s   = 1'b0;
        wr_en_s   = 1'b0;
        acc_idx_s = {bank_q, col_q[CW-1:0]};
        if (rw_ok_s) begin
            state_d   = is_rd_s ? ST_RD : ST_WR;
            bank_d    = sdram_bs;
            col_d     = col_next(sdram_addr[8:0], new_mask_s);
            rem_d     = new_len_s - 10'd1;
            mask_d    = new_mask_s;
            acc_idx_s = {sdram_bs, sdram_addr[CW-1:0]};
            issue_s   = is_rd_s;
            wr_en_s   = is_wr_s;
        end else begin
            case (state_q)
                ST_RD, ST_WR: begin
                    if ((rem_q == 10'd0) || burst_stop_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        issue_s = (state_q == ST_RD);
                        wr_en_s = (state_q == ST_WR);
                        col_d   = col_next(col_q, mask_q);
                        rem_d   = rem_q - 10'd1;
                    end
                end
                ST_IDLE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Protocol checks; 5 outranks 2, which outranks 6.
    always_comb begin
        err_hit_s = 1'b1;
        err_val_s = 3'd0;
        if (is_act_s && open_q[sdram_bs]) begin
            err_val_s = 3'd1;
        end else if (is_ref_s && (open_q != 4'd0)) begin
            err_val_s = 3'd3;
        end else if (is_lmr_s && (open_q != 4'd0)) begin
            err_val_s = 3'd4;
        end else if ((is_rd_s || is_wr_s) && !mode_valid_q) begin
            err_val_s = 3'd5;
        end else if ((is_rd_s || is_wr_s) && !open_q[sdram_bs]) begin
            err_val_s = 3'd2;
        end else if ((is_rd_s || is_wr_s) && (act_cnt_q[sdram_bs] < TRCD_C)) begin
            err_val_s = 3'd6;
        end else begin
            err_hit_s = 1'b0;
        end
    end

    // Bank open flags: ACTIVE opens, PRE closes one bank or all when A10 is set.
    always_comb begin
        open_d = open_q;
        if (is_act_s) begin
            open_d[sdram_bs] = 1'b1;
        end else if (is_pre_s && sdram_addr[10]) begin
            open_d = 4'd0;
        end else if (is_pre_s) begin
            open_d[sdram_bs] = 1'b0;
        end else begin
            open_d = open_q;
        end
    end

    // Control state, bank tracking, mode, errors and the CAS-latency read pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            bank_q       <= 2'd0;
            col_q        <= 9'd0;
            rem_q        <= 10'd0;
            mask_q       <= 9'd0;
            open_q       <= 4'd0;
            mode_valid_q <= 1'b0;
            cl_q         <= 3'd0;
            bl_q         <= 3'd0;
            err_flag_q   <= 1'b0;
            err_code_q   <= 3'd0;
            pv_q         <= 3'd0;
            dq_oe_q      <= 1'b0;
            dq_out_q     <= '0;
            for (int i = 0; i < 3; i++) pd_q[i] <= '0;
            for (int i = 0; i < 4; i++) begin
                act_cnt_q[i] <= 4'd0;
                row_q[i]     <= 13'd0;
            end
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            col_q   <= col_d;
            rem_q   <= rem_d;
            mask_q  <= mask_d;
            open_q  <= open_d;
            for (int i = 0; i < 4; i++) begin
                if (is_act_s && (sdram_bs == 2'(i))) begin
                    act_cnt_q[i] <= 4'd1;
                    row_q[i]     <= sdram_addr;
                end else if (act_cnt_q[i] != 4'hF) begin
                    act_cnt_q[i] <= act_cnt_q[i] + 4'd1;
                end
            end
            if (is_lmr_s) begin
                mode_valid_q <= 1'b1;
                cl_q         <= sdram_addr[6:4];
                bl_q         <= sdram_addr[2:0];
            end
            err_flag_q <= err_hit_s;
            if (err_hit_s) err_code_q <= err_val_s;
            pv_q    <= {pv_q[1:0], issue_s};
            pd_q[0] <= issue_s ? rd_data_s : '0;
            pd_q[1] <= pd_q[0];
            pd_q[2] <= pd_q[1];
            dq_oe_q  <= src_v_s;
            dq_out_q <= src_v_s ? src_d_s : '0;
        end
    end

    // Data store is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) store_q[acc_idx_s] <= sdram_dq_in;
    end

    assign sdram_dq_out   = dq_out_q;
    assign sdram_dq_oe    = dq_oe_q;
    assign mode_valid     = mode_valid_q;
    assign mode_cas_lat   = cl_q;
    assign mode_burst_len = bl_q;
    assign bank_open      = open_q;
    assign err_flag       = err_flag_q;
    assign err_code       = err_code_q;

endmodule

// File: tb/tb_sdram_cmd_responder.sv
// Bench for sdram_cmd_responder: directed bring-up sequences plus random command
// traffic, checked every cycle against a cycle-indexed behavioural model.
module tb_sdram_cmd_responder;

    localparam int DW   = 16;
    localparam int TRCD = 2;
    localparam int MAXE = 8192;

    localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD  = 3'b101, C_WR  = 3'b100,
                           C_BST = 3'b110, C_PRE = 3'b010, C_REF = 3'b001, C_LMR = 3'b000;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cke, cs_n, ras_n, cas_n, we_n;
    logic [1:0]    bs;
    logic [12:0]   addr;
    logic [DW-1:0] dq_in, dq_out;
    logic          dq_oe, mode_valid, err_flag;
    logic [2:0]    mode_cas_lat, mode_burst_len, err_code;
    logic [3:0]    bank_open;

    always #5 clk = ~clk;

    sdram_cmd_responder #(.DATA_W(DW), .STORE_AW(8), .TRCD(TRCD)) dut (
        .clk(clk), .reset_n(reset_n), .sdram_cke(cke), .sdram_cs_n(cs_n),
        .sdram_ras_n(ras_n), .sdram_cas_n(cas_n), .sdram_we_n(we_n),
        .sdram_bs(bs), .sdram_addr(addr), .sdram_dq_in(dq_in),
        .sdram_dq_out(dq_out), .sdram_dq_oe(dq_oe), .mode_valid(mode_valid),
        .mode_cas_lat(mode_cas_lat), .mode_burst_len(mode_burst_len),
        .bank_open(bank_open), .err_flag(err_flag), .err_code(err_code)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: edge-indexed, words derived from burst start and offset.
    bit            m_mval;
    bit [2:0]      m_cl, m_bl, m_ecode;
    bit            m_eflag;
    bit [3:0]      m_open;
    int            m_act [4];
    logic [DW-1:0] m_store [256];
    bit            m_known [256];
    int            b_kind, b_bank, b_start, b_len, b_t0;
    bit            s_v [MAXE];
    bit            s_k [MAXE];
    logic [DW-1:0] s_d [MAXE];
    int            edge_n;
    logic [DW-1:0] rdq [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_n, got, exp);
        end
    endtask

    function automatic int blen(input bit [2:0] code);
        case (code)
            3'd0: return 1;
            3'd1: return 2;
            3'd2: return 4;
            3'd3: return 8;
            3'd7: return 512;
            default: return 1;
        endcase
    endfunction

    function automatic int word_col(input int start, input int len, input int k);
        return ((start & ~(len - 1)) | ((start + k) & (len - 1))) & 511;
    endfunction

    function automatic bit pipe_busy();
        for (int i = 0; i < 5; i++) if (s_v[edge_n + i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_mval = 0; m_cl = 0; m_bl = 0; m_ecode = 0; m_eflag = 0; m_open = 0;
        b_kind = 0;
        for (int i = 0; i < 4; i++) m_act[i] = -100;
        for (int i = 0; i < MAXE; i++) begin
            s_v[i] = 0; s_k[i] = 0; s_d[i] = '0;
        end
    endtask

    task automatic model_issue(input int kind, input int bank, input int col, input logic [DW-1:0] d);
        int idx;
        int lat;
        idx = bank * 64 + (col % 64);
        lat = (m_cl == 3'd2) ? 2 : 3;
        if (kind == 1) begin
            s_v[edge_n + lat] = 1;
            s_k[edge_n + lat] = m_known[idx];
            s_d[edge_n + lat] = m_store[idx];
        end else begin
            m_store[idx] = d;
            m_known[idx] = 1;
        end
    endtask

    // One clock: drive at the falling edge, predict, then check just after the rising edge.
    task automatic do_cycle(input bit ck, input bit csn, input logic [2:0] c, input logic [1:0] b,
                            input logic [12:0] a, input logic [DW-1:0] d);
        bit en, act, rd, wr, bst, pre, rf, lmr, acc;
        int err, k;
        cke = ck; cs_n = csn; {ras_n, cas_n, we_n} = c; bs = b; addr = a; dq_in = d;
        en  = ck && !csn;
        act = en && c == C_ACT; rd  = en && c == C_RD;  wr  = en && c == C_WR;
        bst = en && c == C_BST; pre = en && c == C_PRE; rf  = en && c == C_REF;
        lmr = en && c == C_LMR;
        acc = (rd || wr) && m_mval && m_open[b];
        err = 0;
        if (act && m_open[b]) err = 1;
        else if (rf && m_open != 0) err = 3;
        else if (lmr && m_open != 0) err = 4;
        else if ((rd || wr) && !m_mval) err = 5;
        else if ((rd || wr) && !m_open[b]) err = 2;
        else if ((rd || wr) && (edge_n - m_act[b]) < TRCD) err = 6;
        if (b_kind != 0) begin
            k = edge_n - b_t0;
            if (bst || (pre && (a[10] || b == b_bank)) || acc || k >= b_len) b_kind = 0;
            else model_issue(b_kind, b_bank, word_col(b_start, b_len, k), d);
        end
        if (acc) begin
            b_kind = rd ? 1 : 2; b_bank = b; b_start = a[8:0]; b_len = blen(m_bl); b_t0 = edge_n;
            model_issue(b_kind, b, a[8:0], d);
        end
        if (act) begin m_open[b] = 1; m_act[b] = edge_n; end
        if (pre) begin
            if (a[10]) m_open = 0;
            else m_open[b] = 0;
        end
        if (lmr) begin m_mval = 1; m_cl = a[6:4]; m_bl = a[2:0]; end
        m_eflag = (err != 0);
        if (err != 0) m_ecode = 3'(err);
        @(posedge clk);
        #1;
        check_val("dq_oe", {31'd0, dq_oe}, {31'd0, s_v[edge_n]});
        if (!s_v[edge_n]) check_val("dq_idle", {16'd0, dq_out}, 32'd0);
        else if (s_k[edge_n]) check_val("dq_data", {16'd0, dq_out}, {16'd0, s_d[edge_n]});
        if (dq_oe) rdq.push_back(dq_out);
        check_val("err_flag", {31'd0, err_flag}, {31'd0, m_eflag});
        check_val("err_code", {29'd0, err_code}, {29'd0, m_ecode});
        check_val("bank_open", {28'd0, bank_open}, {28'd0, m_open});
        check_val("mode_valid", {31'd0, mode_valid}, {31'd0, m_mval});
        check_val("mode_cl", {29'd0, mode_cas_lat}, {29'd0, m_cl});
        check_val("mode_bl", {29'd0, mode_burst_len}, {29'd0, m_bl});
        edge_n++;
        @(negedge clk);
    endtask

    task automatic cmd(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a,
                       input logic [DW-1:0] d);
        do_cycle(1'b1, 1'b0, c, b, a, d);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) cmd(C_NOP, 2'd0, 13'd0, 16'd0);
    endtask

    task automatic check_rdq(input string tag, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                             input logic [DW-1:0] w2, input logic [DW-1:0] w3);
        logic [DW-1:0] exp [4];
        exp = '{w0, w1, w2, w3};
        check_val({tag, "_len"}, rdq.size(), 32'd4);
        for (int i = 0; i < 4 && i < rdq.size(); i++)
            check_val(tag, {16'd0, rdq[i]}, {16'd0, exp[i]});
    endtask

    initial begin
        int r;
        logic [12:0] a;
        logic [2:0]  c;
        for (int i = 0; i < 256; i++) begin m_known[i] = 0; m_store[i] = '0; end
        edge_n = 0;
        model_reset();
        reset_n = 1'b0; cke = 1'b1; cs_n = 1'b0; {ras_n, cas_n, we_n} = C_NOP;
        bs = 2'd0; addr = 13'd0; dq_in = 16'd0;
        repeat (3) @(negedge clk);
        check_val("rst_oe", {31'd0, dq_oe}, 32'd0);
        check_val("rst_dq", {16'd0, dq_out}, 32'd0);
        check_val("rst_mode_valid", {31'd0, mode_valid}, 32'd0);
        check_val("rst_bank_open", {28'd0, bank_open}, 32'd0);
        check_val("rst_err", {28'd0, err_flag, err_code}, 32'd0);
        reset_n = 1'b1;

        // Init, then a page-mode write stopped by BST and read back.
        cmd(C_PRE, 2'd0, 13'h1fff, 16'd0);
        cmd(C_REF, 2'd0, 13'd0, 16'd0);
        cmd(C_REF, 2'd0, 13'd0, 16'd0);
        cmd(C_LMR, 2'd0, 13'h037, 16'd0);
        check_val("init_mode_valid", {31'd0, mode_valid}, 32'd1);
        check_val("init_cl", {29'd0, mode_cas_lat}, 32'd3);
        check_val("init_bl", {29'd0, mode_burst_len}, 32'd7);
        check_val("init_noerr", {31'd0, err_flag}, 32'd0);
        cmd(C_ACT, 2'd1, 13'd5, 16'd0);
        nops(2);
        cmd(C_WR, 2'd1, 13'h010, 16'hA000);
        cmd(C_NOP, 2'd0, 13'd0, 16'hA001);
        cmd(C_NOP, 2'd0, 13'd0, 16'hA002);
        cmd(C_NOP, 2'd0, 13'd0, 16'hA003);
        cmd(C_BST, 2'd0, 13'd0, 16'hA004);
        rdq.delete();
        cmd(C_RD, 2'd1, 13'h010, 16'd0);
        nops(3);
        cmd(C_BST, 2'd0, 13'd0, 16'd0);
        nops(5);
        check_rdq("page_rd", 16'hA000, 16'hA001, 16'hA002, 16'hA003);

        // CL=2, BL=4 wrapped read.
        cmd(C_PRE, 2'd0, 13'h0400, 16'd0);
        cmd(C_LMR, 2'd0, 13'h022, 16'd0);
        cmd(C_ACT, 2'd2, 13'd7, 16'd0);
        nops(2);
        cmd(C_WR, 2'd2, 13'h004, 16'hB004);
        cmd(C_NOP, 2'd0, 13'd0, 16'hB005);
        cmd(C_NOP, 2'd0, 13'd0, 16'hB006);
        cmd(C_NOP, 2'd0, 13'd0, 16'hB007);
        cmd(C_NOP, 2'd0, 13'd0, 16'hBFFF);
        rdq.delete();
        cmd(C_RD, 2'd2, 13'h006, 16'd0);
        nops(7);
        check_rdq("wrap_rd", 16'hB006, 16'hB007, 16'hB004, 16'hB005);

        // Read to a closed bank is rejected.
        cmd(C_PRE, 2'd2, 13'h0000, 16'd0);
        rdq.delete();
        cmd(C_RD, 2'd2, 13'h000, 16'd0);
        check_val("closed_flag", {31'd0, err_flag}, 32'd1);
        check_val("closed_code", {29'd0, err_code}, 32'd2);
        nops(5);
        check_val("closed_nodata", rdq.size(), 32'd0);

        // Early read after ACTIVE still returns data.
        cmd(C_ACT, 2'd3, 13'd1, 16'd0);
        nops(2);
        cmd(C_WR, 2'd3, 13'h000, 16'hC000);
        cmd(C_NOP, 2'd0, 13'd0, 16'hC001);
        cmd(C_NOP, 2'd0, 13'd0, 16'hC002);
        cmd(C_NOP, 2'd0, 13'd0, 16'hC003);
        cmd(C_NOP, 2'd0, 13'd0, 16'd0);
        cmd(C_PRE, 2'd3, 13'h0000, 16'd0);
        cmd(C_ACT, 2'd3, 13'd2, 16'd0);
        rdq.delete();
        cmd(C_RD, 2'd3, 13'h000, 16'd0);
        nops(6);
        check_val("trcd_code", {29'd0, err_code}, 32'd6);
        check_rdq("trcd_rd", 16'hC000, 16'hC001, 16'hC002, 16'hC003);

        // Clock-enable low masks an otherwise valid READ.
        do_cycle(1'b0, 1'b0, C_RD, 2'd3, 13'h000, 16'd0);
        nops(4);

        // Reset in the middle of a read burst.
        cmd(C_RD, 2'd3, 13'h000, 16'd0);
        nops(2);
        check_val("pre_rst_oe", {31'd0, dq_oe}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_val("midrst_oe", {31'd0, dq_oe}, 32'd0);
        check_val("midrst_bank_open", {28'd0, bank_open}, 32'd0);
        check_val("midrst_mode_valid", {31'd0, mode_valid}, 32'd0);
        model_reset();
        {ras_n, cas_n, we_n} = C_NOP;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        nops(2);

        // Random traffic.
        cmd(C_PRE, 2'd0, 13'h0400, 16'd0);
        cmd(C_LMR, 2'd0, 13'h023, 16'd0);
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            a = 13'($urandom);
            c = C_NOP;
            if (r < 8) c = C_ACT;
            else if (r < 22) c = C_RD;
            else if (r < 36) c = C_WR;
            else if (r < 40) c = C_BST;
            else if (r < 46) c = C_PRE;
            else if (r < 48) c = C_REF;
            else if (r < 52 && b_kind == 0 && !pipe_busy()) begin
                c = C_LMR;
                a[6:4] = (r < 50) ? 3'($urandom_range(2, 3)) : 3'($urandom);
            end
            if (r >= 52 && r < 60)
                do_cycle(1'b1, 1'b1, 3'($urandom), 2'($urandom), a, 16'($urandom));
            else
                cmd(c, 2'($urandom), a, 16'($urandom));
        end
        nops(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_cmd_responder.md
Name: sdram_cmd_responder

Overview:
- Synthesizable SDRAM device-side responder: the device end of the bus driven by the controller's command generator.
- Decodes the CKE/CS_n/RAS_n/CAS_n/WE_n/BS/ADDR command bus, tracks the mode register and per-bank open rows, and runs read/write bursts against a small internal store.
- Flags protocol violations.
- Used as the on-chip loopback target for controller bring-up and as the DUT-side companion in controller regressions.

Parameters:
- DATA_W, 16, data bus width.
- STORE_AW, 8, internal store address bits; store index = {bs[1:0], col[STORE_AW-3:0]}.
- TRCD, 2, minimum cycles from ACTIVE to READ/WRITE on the same bank.

Ports:
- clk  in  1  clock; all command-bus inputs sampled on the rising edge.
- reset_n  in  1  reset.
- sdram_cke  in  1  clock enable; 0 = cycle ignored.
- sdram_cs_n  in  1  chip select; 1 = deselect (treated as NOP).
- sdram_ras_n  in  1  command bit.
- sdram_cas_n  in  1  command bit.
- sdram_we_n  in  1  command bit.
- sdram_bs  in  2  bank select.
- sdram_addr  in  13  row / column / mode word.
- sdram_dq_in  in  DATA_W  write data from the controller.
- sdram_dq_out  out  DATA_W  read data.
- sdram_dq_oe  out  1  read data valid / drive enable.
- mode_valid  out  1  LMR has been received since reset.
- mode_cas_lat  out  3  latched CAS latency (A6-A4).
- mode_burst_len  out  3  latched burst code (A2-A0).
- bank_open  out  4  per-bank open-row flags.
- err_flag  out  1  one-cycle pulse on a protocol violation.
- err_code  out  3  code of the last violation; held until the next one.

Behaviour:
- Reset: reset_n is the asynchronous, active-low reset; clock is clk. All outputs go to 0 and the burst FSM goes to IDLE. A reset mid-burst aborts the burst with no further data. Store contents are not reset.
- Command code {cke,cs_n,ras_n,cas_n,we_n}, decoded only when cke=1 and cs_n=0:
  - NOP 10111.
  - ACTIVE 10011: open bank bs, latch row = addr.
  - READ 10101.
  - WRITE 10100.
  - BST 10110: burst stop.
  - PRE 10010: addr[10]=1 closes all banks, else closes bank bs.
  - REF 10001.
  - LMR 10000: latch CL = addr[6:4] and BL = addr[2:0]; set mode_valid.
- Burst length from BL code: 000=1, 001=2, 010=4, 011=8, 111=512 (full page). Other codes are treated as 1.
- Column addressing is sequential and wraps within the aligned burst block; full page wraps mod 512.
- Burst FSM states: IDLE, RD, WR.
  - READ/WRITE from any state loads bank, start column and the remaining-word counter, then enters RD/WR. A new READ/WRITE interrupts the current burst.
  - A burst ends when the counter reaches 0, on BST, or on PRE addressing the burst's bank (single or all). The FSM returns to IDLE.
- Read timing:
  - READ sampled at edge T0. The address generator issues one column per cycle starting at T0 into a CL-deep pipeline.
  - Word k appears on sdram_dq_out with dq_oe=1 after edge T0+CL+k.
  - Supported CL: 2 and 3; any other value is treated as 3.
  - BST or interrupt at edge Tb stops issuing new columns. Words already in the pipeline still emerge, so the last word is after edge Tb+CL-1.
  - dq_oe=0 whenever no pipeline slot is valid; dq_out is then 0.
- Write timing:
  - dq_in is written on the WRITE edge (word 0) and on each following edge while in WR.
  - Data present on the BST edge, or on the edge of an interrupting command, is not written; the interrupting WRITE's own word 0 is written.
- Error codes: err_flag pulses for one cycle and err_code updates; the command still executes except where noted.
  - 1: ACTIVE to an already-open bank; row is overwritten.
  - 2: READ/WRITE to a closed bank; command ignored.
  - 3: REF with any bank open.
  - 4: LMR with any bank open; mode is still latched.
  - 5: READ/WRITE with mode_valid=0; command ignored.
  - 6: READ/WRITE fewer than TRCD cycles after ACTIVE on the same bank; command executes.
- Error priority when several apply: 5 > 2 > 6.
- A per-bank saturating counter tracks cycles since ACTIVE.
- Simultaneous events: the burst end and a new command on the same edge resolve to the new command.

Test Plan:
- Init sequence: PRE(addr=1fff), REF, REF, LMR addr=0x037 -> mode_valid=1, mode_cas_lat=3, mode_burst_len=7, no err_flag.
- After init: ACTIVE bs=1 row=5; wait 2 cycles; WRITE col=0x010 with dq_in 0xA000..0xA003 on 4 edges; BST on the 5th edge -> store[{1,0x10..0x13}] hold A000..A003; the 5th-edge data is not written.
- READ bs=1 col=0x010 at T0 with CL=3; BST at T0+4 -> dq_oe=1 after edges T0+3..T0+6 with A000..A003; dq_oe=0 after T0+7.
- LMR 0x022 (CL=2, BL=4); ACTIVE; READ col=6 -> data order col 6, 7, 4, 5 starting after edge T0+2; dq_oe drops after 4 words with no BST.
- READ to closed bank 2 -> err_flag pulse, err_code=2, dq_oe stays 0.
- READ one cycle after ACTIVE (TRCD=2) -> err_code=6 and read data still returned.
- Assert reset_n=0 mid-read burst -> dq_oe=0 immediately, bank_open=0, mode_valid=0.
